bcd_countdown_timer: RTL and testbench

//  Parametrised N-digit BCD set/countdown counter with direct 7-segment outputs.
//  - SET mode: value is loaded with debounced up/down keys.
//  - RUN mode: value counts down once per TICK_DIV clocks, stops at zero and pulses done.
//  - Sits between the board keys/switch and the seven-segment digit drivers.

---
 rtl/bcd_countdown_timer.sv | 216 +++++++++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer
//   N-digit BCD value with two operating modes:
//     SET - the value is edited with two debounced, active-low push buttons
//           (up/down, BCD-correct, wrapping between 0 and MAX_VALUE).
//     RUN - the value counts down one step every TICK_DIV enabled clocks,
//           stops at zero and pulses done for one cycle.
//   Each digit is also decoded to an active-high 7-segment pattern.
//
// Ports
//   clk     in  1              rising-edge clock
//   reset   in  1              synchronous, active-low
//   mode    in  1              1 = SET, 0 = RUN
//   key_up  in  1              active-low button, increment in SET
//   key_dn  in  1              active-low button, decrement in SET
//   run_en  in  1              1 = countdown advances, 0 = pause
//   bcd     out 4*NUM_DIGITS   current value, packed BCD (digit 0 = LSD)
//   seg     out 7*NUM_DIGITS   segments {g..a} per digit, digit d at [7d+6:7d]
//   busy    out 1              high while counting down
//   done    out 1              one-cycle pulse when the count reaches zero
module bcd_countdown_timer #(
  parameter int NUM_DIGITS      = 2,
  parameter int MAX_VALUE       = 30,
  parameter int TICK_DIV        = 12000000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic                    key_up,
  input  logic                    key_dn,
  input  logic                    run_en,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [7*NUM_DIGITS-1:0] seg,
  output logic                    busy,
  output logic                    done
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  function automatic logic [BW-1:0] to_bcd(input int v);
    int r;
    r      = v;
    to_bcd = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      to_bcd[4*d +: 4] = 4'(r % 10);
      r = r / 10;
    end
  endfunction

  localparam logic [BW-1:0] MAX_BCD = to_bcd(MAX_VALUE);

  // Ripple the +1 through the digits; a 9 rolls to 0 and carries on.
  function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
    logic       carry;
    logic [3:0] dig;
    carry   = 1'b1;
    bcd_inc = v;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      dig = v[4*d +: 4];
      if (carry) begin
        if (dig == 4'd9) begin
          bcd_inc[4*d +: 4] = 4'd0;
        end else begin
          bcd_inc[4*d +: 4] = dig + 4'd1;
          carry = 1'b0;
        end
      end
    end
  endfunction

  // Ripple the -1 through the digits; a 0 rolls to 9 and borrows on.
  function automatic logic [BW-1:0] bcd_dec(input logic [BW-1:0] v);
    logic       borrow;
    logic [3:0] dig;
    borrow  = 1'b1;
    bcd_dec = v;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      dig = v[4*d +: 4];
      if (borrow) begin
        if (dig == 4'd0) begin
          bcd_dec[4*d +: 4] = 4'd9;
        end else begin
          bcd_dec[4*d +: 4] = dig - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  typedef enum logic [1:0] {
    S_SET,
    S_RUN,
    S_EXPIRED
  } state_t;

  state_t          state;
  logic [BW-1:0]   value;
  logic [PW-1:0]   presc;
  logic            key_up_p0, key_up_p1;
  logic            key_dn_p0, key_dn_p1;
  logic [DW-1:0]   up_cnt, dn_cnt;
  logic            up_evt, dn_evt;

  // Stage p0 -> p1: two-flop synchronisers; idle level of the keys is high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      key_up_p0 <= 1'b1;
      key_up_p1 <= 1'b1;
      key_dn_p0 <= 1'b1;
      key_dn_p1 <= 1'b1;
    end else begin
      key_up_p0 <= key_up;
      key_up_p1 <= key_up_p0;
      key_dn_p0 <= key_dn;
      key_dn_p1 <= key_dn_p0;
    end
  end

  // Stage p1 -> hold counters: count consecutive low samples, saturate at
  // DEBOUNCE_CYCLES so a long hold yields a single event.
  always_ff @(posedge clk) begin
    if (!reset) begin
      up_cnt <= '0;
      dn_cnt <= '0;
    end else begin
      if (!mode || key_up_p1)
        up_cnt <= '0;
      else if (up_cnt != DW'(DEBOUNCE_CYCLES))
        up_cnt <= up_cnt + DW'(1);

      if (!mode || key_dn_p1)
        dn_cnt <= '0;
      else if (dn_cnt != DW'(DEBOUNCE_CYCLES))
        dn_cnt <= dn_cnt + DW'(1);
    end
  end

  // The event fires on the edge where the counter steps onto DEBOUNCE_CYCLES,
  // so the value changes on that same edge.
  assign up_evt = mode && !key_up_p1 && (up_cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign dn_evt = mode && !key_dn_p1 && (dn_cnt == DW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_SET;
      value <= '0;
      presc <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_SET: begin
          presc <= '0;
          if (!mode) begin
            state <= (value != '0) ? S_RUN : S_EXPIRED;
          end else if (up_evt && !dn_evt) begin
            value <= (value == MAX_BCD) ? '0 : bcd_inc(value);
          end else if (dn_evt && !up_evt) begin
            value <= (value == '0) ? MAX_BCD : bcd_dec(value);
          end
        end
        S_RUN: begin
          // A mode change takes priority over a tick landing on the same edge.
          if (mode) begin
            state <= S_SET;
          end else if (run_en) begin
            if (presc == PW'(TICK_DIV - 1)) begin
              presc <= '0;
              value <= bcd_dec(value);
              if (value == BW'(1)) begin
                done  <= 1'b1;
                state <= S_EXPIRED;
              end
            end else begin
              presc <= presc + PW'(1);
            end
          end
        end
        S_EXPIRED: begin
          presc <= '0;
          if (mode)
            state <= S_SET;
        end
        default: state <= S_SET;
      endcase
    end
  end

  assign bcd  = value;
  assign busy = (state == S_RUN);

  always_comb begin
    seg = '0;
    for (int d = 0; d < NUM_DIGITS; d++)
      seg[7*d +: 7] = seg7(value[4*d +: 4]);
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer (2 digits, max 30, tick 10, debounce 4).
// Expected values are pushed to a scoreboard queue as stimulus is applied and
// popped when the corresponding DUT output is sampled.
module tb_bcd_countdown_timer;

  localparam int ND = 2;
  localparam int MV = 30;
  localparam int TD = 10;
  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic        key_up;
  logic        key_dn;
  logic        run_en;
  logic [7:0]  bcd;
  logic [13:0] seg;
  logic        busy;
  logic        done;

  bcd_countdown_timer #(
    .NUM_DIGITS      (ND),
    .MAX_VALUE       (MV),
    .TICK_DIV        (TD),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .mode   (mode),
    .key_up (key_up),
    .key_dn (key_dn),
    .run_en (run_en),
    .bcd    (bcd),
    .seg    (seg),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   mv       = 0;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [7:0] tb_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [13:0] tb_seg(input int v);
    return {seg_of(v / 10), seg_of(v % 10)};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty observed=%0h required=nothing", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic press(input logic u, input logic d, input int hold);
    key_up = ~u;
    key_dn = ~d;
    step(hold);
    key_up = 1'b1;
    key_dn = 1'b1;
    step(3);
  endtask

  task automatic up_n(input int n);
    for (int i = 0; i < n; i++) begin
      press(1'b1, 1'b0, DC + 2);
      mv = (mv == MV) ? 0 : mv + 1;
    end
  endtask

  task automatic dn_n(input int n);
    for (int i = 0; i < n; i++) begin
      press(1'b0, 1'b1, DC + 2);
      mv = (mv == 0) ? MV : mv - 1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset  = 1'b0;
    mode   = 1'b1;
    key_up = 1'b1;
    key_dn = 1'b1;
    run_en = 1'b1;
    expect_val("rst_bcd", 32'h00);
    expect_val("rst_seg", 32'h1FBF);
    expect_val("rst_busy", 32'h0);
    expect_val("rst_done", 32'h0);
    step(2);
    check(bcd); check(seg); check(busy); check(done);
    reset = 1'b1;
    step(1);

    // Load 17, start running, then reset mid-RUN
    up_n(17);
    expect_val("load17", tb_bcd(mv));
    check(bcd);
    mode = 1'b0;
    expect_val("run17_busy", 32'h1);
    expect_val("run17_bcd", tb_bcd(17));
    step(3);
    check(busy); check(bcd);
    reset = 1'b0;
    expect_val("rstrun_bcd", 32'h00);
    expect_val("rstrun_seg", 32'h1FBF);
    expect_val("rstrun_busy", 32'h0);
    expect_val("rstrun_done", 32'h0);
    step(1);
    check(bcd); check(seg); check(busy); check(done);
    mode  = 1'b1;
    reset = 1'b1;
    mv    = 0;
    step(1);

    // Debounce timing: one increment at edge DC+2 of a long hold
    key_up = 1'b0;
    expect_val("hold_edge5", tb_bcd(0));
    step(DC + 1);
    check(bcd);
    expect_val("hold_edge6", tb_bcd(1));
    step(1);
    check(bcd);
    expect_val("hold_long", tb_bcd(1));
    step(14);
    check(bcd);
    key_up = 1'b1;
    step(3);
    mv = 1;
    up_n(12);
    expect_val("up13_bcd", tb_bcd(13));
    expect_val("up13_seg", tb_seg(13));
    check(bcd); check(seg);

    // Short glitch must not count
    key_up = 1'b0;
    step(3);
    key_up = 1'b1;
    expect_val("glitch", tb_bcd(13));
    step(6);
    check(bcd);

    // Wrap boundaries and simultaneous keys
    up_n(17);
    expect_val("up30", tb_bcd(30));
    check(bcd);
    up_n(1);
    expect_val("wrap_up", tb_bcd(0));
    check(bcd);
    dn_n(1);
    expect_val("wrap_dn", tb_bcd(30));
    check(bcd);
    press(1'b1, 1'b1, 10);
    expect_val("both_keys", tb_bcd(30));
    check(bcd);
    dn_n(18);
    expect_val("load12", tb_bcd(12));
    check(bcd);

    // Countdown from 12 to 0
    mode = 1'b0;
    expect_val("enter_busy", 32'h1);
    expect_val("enter_bcd", tb_bcd(12));
    step(1);
    check(busy); check(bcd);
    expect_val("pre_tick", tb_bcd(12));
    step(TD - 1);
    check(bcd);
    expect_val("tick11", tb_bcd(11));
    step(1);
    check(bcd);
    expect_val("tick10", tb_bcd(10));
    step(TD);
    check(bcd);
    expect_val("tick09", tb_bcd(9));
    expect_val("seg_lo_9", 32'h6F);
    expect_val("seg_hi_0", 32'h3F);
    step(TD);
    check(bcd); check(32'(seg[6:0])); check(32'(seg[13:7]));
    for (int v = 8; v >= 1; v--) begin
      expect_val("count_down", tb_bcd(v));
      step(TD);
      check(bcd);
    end
    expect_val("last_bcd", tb_bcd(1));
    expect_val("last_done", 32'h0);
    expect_val("last_busy", 32'h1);
    step(TD - 1);
    check(bcd); check(done); check(busy);
    expect_val("zero_bcd", tb_bcd(0));
    expect_val("zero_done", 32'h1);
    expect_val("zero_busy", 32'h0);
    step(1);
    check(bcd); check(done); check(busy);
    expect_val("done_once", 32'h0);
    step(1);
    check(done);
    expect_val("exp_bcd", tb_bcd(0));
    expect_val("exp_busy", 32'h0);
    expect_val("exp_done", 32'h0);
    step(3 * TD);
    check(bcd); check(busy); check(done);

    // Pause with run_en low
    mode = 1'b1;
    expect_val("back_set", 32'h0);
    step(1);
    check(busy);
    mv = 0;
    up_n(5);
    mode   = 1'b0;
    run_en = 1'b0;
    expect_val("pause_busy", 32'h1);
    step(1);
    check(busy);
    expect_val("paused", tb_bcd(5));
    step(24);
    check(bcd);
    run_en = 1'b1;
    expect_val("resume_pre", tb_bcd(5));
    step(TD - 1);
    check(bcd);
    expect_val("resume_tick", tb_bcd(4));
    step(1);
    check(bcd);

    // Leave RUN mid-count, edit, re-enter and leave again at 07
    mode = 1'b1;
    expect_val("edit_busy", 32'h0);
    expect_val("edit_bcd", tb_bcd(4));
    step(1);
    check(busy); check(bcd);
    mv = 4;
    up_n(3);
    mode = 1'b0;
    expect_val("run07_busy", 32'h1);
    expect_val("run07_bcd", tb_bcd(7));
    step(5);
    check(busy); check(bcd);
    mode = 1'b1;
    expect_val("stop07_busy", 32'h0);
    expect_val("stop07_bcd", tb_bcd(7));
    step(1);
    check(busy); check(bcd);
    up_n(1);
    expect_val("keys_again", tb_bcd(8));
    check(bcd);

    // Mode change on the tick edge: no decrement, no done
    mode = 1'b0;
    step(TD);
    mode = 1'b1;
    expect_val("race_bcd", tb_bcd(8));
    expect_val("race_done", 32'h0);
    expect_val("race_busy", 32'h0);
    step(1);
    check(bcd); check(done); check(busy);

    // Starting from zero goes straight to EXPIRED
    dn_n(8);
    expect_val("zero_load", tb_bcd(0));
    check(bcd);
    mode = 1'b0;
    for (int i = 0; i < 15; i++) begin
      expect_val("expz_busy", 32'h0);
      expect_val("expz_done", 32'h0);
      step(1);
      check(busy); check(done);
    end
    expect_val("expz_bcd", tb_bcd(0));
    check(bcd);
    mode = 1'b1;
    step(1);

    // Reset during a key hold discards the partial count
    key_up = 1'b0;
    step(4);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    expect_val("rsthold_early", tb_bcd(0));
    step(3);
    check(bcd);
    expect_val("rsthold_late", tb_bcd(1));
    step(6);
    check(bcd);
    key_up = 1'b1;
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
